divider: RTL and testbench
==========================

# divider

Iterative restoring shift-subtract divider for the RV32M DIV/DIVU/REM/REMU instructions. It is the inverse counterpart of the core's shift-add multiplier. The execute stage launches it with a one-cycle start strobe. It computes one quotient bit per cycle and returns quotient and remainder together, with a one-cycle done pulse and a fixed latency. Division by zero and signed overflow follow the RISC-V spec, so no trap logic is needed downstream.

## Interface
- WIDTH, 32, operand/result width; the counter width is derived as clog2(WIDTH)+1.
- clk_i  input  1  core clock; all state updates on rising edge.
- rst_i  input  1  reset. Synchronous, active-high.
- start_i  input  1  launch strobe; sampled only in IDLE.
- signed_i  input  1  1 = DIV/REM (two's complement), 0 = DIVU/REMU; captured with start.
- dividend_i  input  WIDTH  dividend; captured with start.
- divisor_i  input  WIDTH  divisor; captured with start.
- busy_o  output  1  high while an operation is in flight.
- done_o  output  1  one-cycle pulse; quotient_o and remainder_o are valid in that cycle.
- quotient_o  output  WIDTH  quotient, registered; held until the next result write.
- remainder_o  output  WIDTH  remainder, registered; held until the next result write.

## Operation
- States:
  - IDLE: accept.
  - CALC: WIDTH iterations.
  - FIX: sign correction and result write.
- IDLE, start_i=1:
  - Latch the magnitudes of the operands: |x| when signed_i and x[WIDTH-1], else x.
  - Latch neg_q = signed_i & (dividend sign XOR divisor sign) & (divisor != 0).
  - Latch neg_r = signed_i & dividend sign.
  - Latch div_zero = (divisor_i == 0).
  - Clear the partial remainder R (WIDTH+1 bits) and load Q = |dividend|.
  - Clear the counter, then go to CALC.
- CALC iteration:
  - {R,Q} shifted left 1.
  - Trial T = R - {0,|divisor|}.
  - If T is non-negative: R = T and Q[0] = 1. Otherwise R is kept and Q[0] = 0.
  - Counter increments; after iteration WIDTH, go to FIX.
- FIX:
  - quotient_o = neg_q ? -Q : Q.
  - remainder_o = neg_r ? -R[WIDTH-1:0] : R[WIDTH-1:0].
  - Assert done_o, go to IDLE.
- Divide by zero:
  - The normal path yields Q = all ones and R = |dividend|. neg_q is forced to 0, so quotient_o = 0xFFFFFFFF and remainder_o = dividend_i. No special latency.
- Signed overflow (0x80000000 / 0xFFFFFFFF):
  - The normal path yields quotient_o = 0x80000000 and remainder_o = 0, as the spec requires.
- start_i while busy_o=1: ignored; the captured operands are unaffected.
- All subtraction and negation are modulo 2^WIDTH, except the WIDTH+1-bit trial compare.

## Timing
- Edge E0 samples start_i=1 in IDLE.
- busy_o is high in the cycles following E0 through E(WIDTH+1).
- Edges E1..EWIDTH perform the iterations.
- Edge E(WIDTH+1) writes the results. In the following cycle, done_o=1 and busy_o=0.
- Latency is always WIDTH+1 edges (33 for WIDTH=32), independent of operand values.
- done_o is high exactly one cycle. The state is IDLE in that cycle, so a start_i there is accepted (back-to-back issue, throughput 1 op per WIDTH+2 cycles).
- Reset values: busy_o=0, done_o=0, quotient_o=0, remainder_o=0, state=IDLE, counter=0.
- rst_i mid-operation: at the next edge, return to IDLE with all outputs at reset values. No done_o is produced for the aborted operation.
- rst_i and start_i high together: reset wins; the operation is not started.
- Outputs change only at the FIX write or on reset, never during CALC.

## Test plan
- Unsigned 100 / 7 (signed_i=0): done_o 33 cycles after start; quotient_o=14, remainder_o=2.
- Signed -7 / 2 (0xFFFFFFF9 / 0x2): quotient_o=0xFFFFFFFD (-3), remainder_o=0xFFFFFFFF (-1). Also 7 / -2: quotient_o=0xFFFFFFFD, remainder_o=1.
- Divide by zero:
  - signed 0xFFFFFFF9 / 0: quotient_o=0xFFFFFFFF, remainder_o=0xFFFFFFF9.
  - unsigned 0x12345678 / 0: quotient_o=0xFFFFFFFF, remainder_o=0x12345678.
  - Both with 33-cycle latency.
- Overflow and unsigned max:
  - signed 0x80000000 / 0xFFFFFFFF: quotient_o=0x80000000, remainder_o=0.
  - unsigned 0xFFFFFFFF / 0xFFFFFFFF: quotient_o=1, remainder_o=0.
- Start 100/7, re-pulse start_i with 50/5 at cycle 10, then start 50/5 in the done_o cycle:
  - The first done_o gives 14/2.
  - The second done_o comes 33 cycles later and gives 10/0.
  - done_o is never wider than 1 cycle.
- Start 100/7, assert rst_i at cycle 15 for 1 cycle: busy_o=0 and quotient_o=remainder_o=0 after that edge, and no done_o follows. A fresh 9/4 then gives quotient_o=2, remainder_o=1.

Source files
------------

// File: rtl/divider.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; fixed latency of WIDTH+1 edges from start to result.
//
// state | meaning
// IDLE  | waiting for start_i; outputs hold the last result
// CALC  | WIDTH shift-subtract iterations
// FIX   | sign correction and result write
module divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // The partial remainder always stays below the divisor, so its extra
  // top bit is zero between iterations and only exists in the trial subtract.
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;

  // Operand magnitudes and the trial subtraction for the current iteration
  always_comb begin
    dvd_mag   = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
    dvs_mag   = (signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvs_q};
  end

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          quo_d     = dvd_mag;
          dvs_d     = dvs_mag;
          // A zero divisor keeps the quotient unsigned all-ones.
          neg_quo_d = signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1])
                      & (divisor_i != '0);
          neg_rem_d = signed_i & dividend_i[WIDTH-1];
          rem_d     = '0;
          cnt_d     = '0;
          state_d   = CALC;
        end
      end
      CALC: begin
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        rem_d = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        quotient_d  = neg_quo_q ? -quo_q : quo_q;
        remainder_d = neg_rem_q ? -rem_q : rem_q;
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
    end
  end

  // Output drive
  always_comb begin
    busy_o      = (state_q != IDLE);
    done_o      = done_q;
    quotient_o  = quotient_q;
    remainder_o = remainder_q;
  end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for the divider: the driver pushes expected results,
// a negedge monitor pops and compares on every done_o.
module tb_divider;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] quotient_o;
  logic [31:0] remainder_o;

  divider #(.WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic        prev_done = 1'b0;
  logic [31:0] prev_q = '0;
  logic [31:0] prev_r = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: output hold during busy, done width, scoreboard compare
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy_o) begin
        chk("hold_quotient", quotient_o, prev_q);
        chk("hold_remainder", remainder_o, prev_r);
      end
      if (done_o) begin
        chk("done_width", {31'd0, prev_done}, 32'd0);
        chk("busy_in_done", {31'd0, busy_o}, 32'd0);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done_o=1 with no operation pending (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("quotient", quotient_o, e.q);
          chk("remainder", remainder_o, e.r);
          chk("latency", 32'(cyc), 32'(e.cyc));
        end
      end
    end
    prev_done = done_o;
    prev_q    = quotient_o;
    prev_r    = remainder_o;
  end

  // Called at a negedge; start is sampled by the next posedge (E0),
  // done becomes visible at the negedge after E33.
  task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] eq, input logic [31:0] er);
    exp_t e;
    signed_i   = sgn;
    dividend_i = a;
    divisor_i  = b;
    start_i    = 1'b1;
    if (push) begin
      e.q   = eq;
      e.r   = er;
      e.cyc = cyc + 34;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done_o) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_done: no done_o within %0d cycles (cycle %0d)", max_cyc, cyc);
  endtask

  task automatic run_vec(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er);
    issue(sgn, a, b, 1'b1, eq, er);
    wait_done(60);
    @(negedge clk);
  endtask

  initial begin
    rst_i      = 1'b1;
    start_i    = 1'b0;
    signed_i   = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    chk("reset_done", {31'd0, done_o}, 32'd0);
    chk("reset_quotient", quotient_o, 32'd0);
    chk("reset_remainder", remainder_o, 32'd0);
    mon_en = 1'b1;

    run_vec(1'b0, 32'd100,       32'd7,          32'd14,         32'd2);
    run_vec(1'b1, 32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFD,  32'hFFFF_FFFF);
    run_vec(1'b1, 32'h7,         32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'h1);
    run_vec(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE,  32'h3,          32'hFFFF_FFFF);
    run_vec(1'b1, 32'hFFFF_FFF9, 32'h0,          32'hFFFF_FFFF,  32'hFFFF_FFF9);
    run_vec(1'b0, 32'h1234_5678, 32'h0,          32'hFFFF_FFFF,  32'h1234_5678);
    run_vec(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000,  32'h0);
    run_vec(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h1,          32'h0);
    run_vec(1'b0, 32'hFFFF_FFFF, 32'h10,         32'h0FFF_FFFF,  32'hF);

    // Re-pulse while busy is ignored; back-to-back issue in the done cycle
    issue(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2);
    repeat (8) @(negedge clk);
    chk("busy_mid_calc", {31'd0, busy_o}, 32'd1);
    issue(1'b0, 32'd50, 32'd5, 1'b0, 32'd0, 32'd0);
    wait_done(60);
    issue(1'b0, 32'd50, 32'd5, 1'b1, 32'd10, 32'd0);
    wait_done(60);
    @(negedge clk);

    // Reset mid-operation aborts without a done pulse
    issue(1'b0, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0);
    repeat (13) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_quotient", quotient_o, 32'd0);
    chk("abort_remainder", remainder_o, 32'd0);
    repeat (40) @(negedge clk);
    run_vec(1'b0, 32'd9, 32'd4, 32'd2, 32'd1);

    // Reset and start together: reset wins
    rst_i = 1'b1;
    issue(1'b0, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0);
    rst_i = 1'b0;
    chk("rst_start_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_start_quotient", quotient_o, 32'd0);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
